// File: rtl/sonic_echo_model.sv
// sonic_echo_model: HC-SR04 responder that turns an accepted trig pulse into a distance-coded echo pulse
module sonic_echo_model #(
  parameter int unsigned TRIG_MIN_CYC = 1000,
  parameter int unsigned BURST_CYC    = 20000,
  parameter int unsigned CYC_PER_CM   = 5800,
  parameter int unsigned MAX_CM       = 400,
  parameter int unsigned TIMEOUT_CYC  = 3800000,
  parameter int unsigned HOLDOFF_CYC  = 6000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trig,
  input  logic [8:0] distance_cm,
  output logic       echo,
  output logic       busy,
  output logic       short_trig
);
  typedef enum logic [2:0] {IDLE, TRIG_HI, BURST, ECHO, HOLDOFF} state_t;
  state_t state;
  logic trig_m, trig_s, trig_s_d;
  logic rise, fall;
  logic [31:0] hi_cnt, cnt, width, new_width;
  always_comb begin
    rise = trig_s & ~trig_s_d;
    fall = ~trig_s & trig_s_d;
    new_width = (distance_cm != '0 && 32'(distance_cm) <= MAX_CM) ? 32'(distance_cm) * CYC_PER_CM : TIMEOUT_CYC;
  end
  // one down-counter serves BURST, ECHO and HOLDOFF; reloaded with (length - 1) on entry
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {trig_m, trig_s, trig_s_d} <= '0;
      state <= IDLE;
      hi_cnt <= '0;
      cnt <= '0;
      width <= '0;
      echo <= 1'b0;
      busy <= 1'b0;
      short_trig <= 1'b0;
    end else begin
      {trig_m, trig_s, trig_s_d} <= {trig, trig_m, trig_s};
      short_trig <= 1'b0;
      case (state)
        IDLE:
          if (rise) begin
            state <= TRIG_HI;
            hi_cnt <= '0;
          end
        TRIG_HI:
          if (fall && hi_cnt >= TRIG_MIN_CYC) begin
            state <= BURST;
            width <= new_width;
            cnt <= BURST_CYC - 1;
            busy <= 1'b1;
          end else if (fall) begin
            state <= IDLE;
            short_trig <= 1'b1;
          end else if (trig_s && hi_cnt < TRIG_MIN_CYC) hi_cnt <= hi_cnt + 1;
        BURST:
          if (cnt == '0) begin
            state <= ECHO;
            cnt <= width - 1;
            echo <= 1'b1;
          end else cnt <= cnt - 1;
        ECHO:
          if (cnt == '0) begin
            state <= HOLDOFF;
            cnt <= HOLDOFF_CYC - 1;
            echo <= 1'b0;
          end else cnt <= cnt - 1;
        HOLDOFF:
          if (cnt == '0) begin
            state <= IDLE;
            busy <= 1'b0;
          end else cnt <= cnt - 1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_sonic_echo_model.sv
// tb_sonic_echo_model: vector table plus corner sequences, echo widths checked through a scoreboard queue
module tb_sonic_echo_model;
  localparam int TRIG_MIN = 5, BURST = 10, CPC = 4, MAXCM = 400, TMO = 2000, HOLD = 50;
  logic clk = 1'b0, rst_n = 1'b0, trig = 1'b0;
  logic [8:0] distance_cm = '0;
  logic echo, busy, short_trig;
  int tests = 0, failed = 0;
  int exp_q[$];
  int echo_len = 0, echo_pulses = 0, busy_run = 0, busy_len = 0, short_cnt = 0;
  bit busy_seen = 0;
  typedef struct {logic [8:0] d; int n; bit acc; int w;} vec_t;
  vec_t tbl [8];
  sonic_echo_model #(
    .TRIG_MIN_CYC(TRIG_MIN), .BURST_CYC(BURST), .CYC_PER_CM(CPC),
    .MAX_CM(MAXCM), .TIMEOUT_CYC(TMO), .HOLDOFF_CYC(HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .trig(trig), .distance_cm(distance_cm),
    .echo(echo), .busy(busy), .short_trig(short_trig)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst_n) begin
      echo_len = 0;
      busy_run = 0;
    end else begin
      if (echo) echo_len++;
      else if (echo_len > 0) begin
        echo_pulses++;
        if (exp_q.size() == 0) check("unexpected echo", echo_len, 0);
        else check("echo width", echo_len, exp_q.pop_front());
        echo_len = 0;
      end
      if (busy) begin
        busy_run++;
        busy_seen = 1;
      end else if (busy_run > 0) begin
        busy_len = busy_run;
        busy_run = 0;
      end
      if (short_trig) short_cnt++;
    end
  end
  task automatic pulse(input logic [8:0] d, input int n);
    @(negedge clk);
    distance_cm = d;
    trig = 1'b1;
    repeat (n) @(negedge clk);
    trig = 1'b0;
  endtask
  task automatic wait_echo(input bit lvl, output int k);
    k = 0;
    while (echo !== lvl && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (echo !== lvl) check("echo wait timeout", echo, lvl);
  endtask
  task automatic run_ok(input logic [8:0] d, input int n, input int w);
    int k, sc;
    sc = short_cnt;
    exp_q.push_back(w);
    pulse(d, n);
    wait_echo(1'b1, k);
    check("echo latency", k, BURST + 3);
    k = 0;
    while (busy && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check("busy release", busy, 0);
    @(negedge clk);
    check("busy length", busy_len, BURST + w + HOLD);
    check("no short_trig", short_cnt - sc, 0);
  endtask
  task automatic run_short(input logic [8:0] d, input int n);
    int sc, ep;
    sc = short_cnt;
    ep = echo_pulses;
    busy_seen = 0;
    pulse(d, n);
    repeat (40) @(negedge clk);
    check("short_trig count", short_cnt - sc, 1);
    check("short no echo", echo_pulses - ep + echo_len, 0);
    check("short busy", busy_seen, 0);
  endtask
  initial begin
    #20_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int k, ep, sc;
    tbl = '{'{9'd25, 8, 1, 100}, '{9'd7, 3, 0, 0}, '{9'd0, 8, 1, TMO}, '{9'd450, 8, 1, TMO},
            '{9'd400, 8, 1, 1600}, '{9'd1, 200, 1, 4}, '{9'd511, 8, 1, TMO}, '{9'd3, 1, 0, 0}};
    #1;
    check("reset echo", echo, 0);
    check("reset busy", busy, 0);
    check("reset short", short_trig, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle busy", busy, 0);
    for (int i = 0; i < 8; i++)
      if (tbl[i].acc) run_ok(tbl[i].d, tbl[i].n, tbl[i].w);
      else run_short(tbl[i].d, tbl[i].n);
    // distance change in BURST, retriggers in ECHO and HOLDOFF, trig still high at HOLDOFF end
    ep = echo_pulses;
    sc = short_cnt;
    exp_q.push_back(40);
    pulse(10, 8);
    repeat (5) @(negedge clk);
    distance_cm = 300;
    wait_echo(1'b1, k);
    pulse(300, 8);
    wait_echo(1'b0, k);
    pulse(300, 8);
    repeat (4) @(negedge clk);
    trig = 1'b1;
    k = 0;
    while (busy && k < 5000) begin
      @(negedge clk);
      k++;
    end
    repeat (20) @(negedge clk);
    trig = 1'b0;
    repeat (20) @(negedge clk);
    check("retrig echo count", echo_pulses - ep, 1);
    check("retrig short", short_cnt - sc, 0);
    check("retrig busy", busy, 0);
    check("retrig queue", exp_q.size(), 0);
    // asynchronous reset in the middle of an echo
    pulse(25, 8);
    wait_echo(1'b1, k);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async rst echo", echo, 0);
    check("async rst busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_ok(5, 8, 20);
    check("final queue", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/sonic_echo_model.md
Name: sonic_echo_model

Overview:
- Synthesizable responder model of the HC-SR04 ultrasonic sensor: the far end of the trig/echo interface that the ultrasonic driver (sonic_top) initiates.
- Accepts a trigger pulse, waits a fixed burst interval, then drives an echo pulse whose width encodes a programmed distance in centimetres.
- Used on the bench and in FPGA self-test builds in place of the physical sensor, so the obstacle-stop FSM can be exercised with known distances.

Parameters:
- TRIG_MIN_CYC, 1000, minimum trig high time in clk cycles (10 us @ 100 MHz).
- BURST_CYC, 20000, delay from accepted trigger to echo rise (200 us burst).
- CYC_PER_CM, 5800, echo high cycles per centimetre (58 us/cm @ 100 MHz).
- MAX_CM, 400, largest in-range distance.
- TIMEOUT_CYC, 3800000, echo width for out-of-range / no object (38 ms).
- HOLDOFF_CYC, 6000000, dead time after echo falls before a new trigger is accepted (60 ms).

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- trig, input, 1, trigger from the initiator; asynchronous, 2-FF synchronised internally.
- distance_cm, input, 9, target distance; sampled once per measurement.
- echo, output, 1, echo pulse to the initiator; registered.
- busy, output, 1, high in every state except IDLE and TRIG_HI.
- short_trig, output, 1, one-cycle pulse when a trigger is rejected as too short.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; echo=0, busy=0, short_trig=0; synchroniser flops, counters and latched distance cleared. Reset mid-echo drops echo immediately, without waiting for a clock.
- trig passes a 2-FF synchroniser. All edges are detected on the synchronised signal (trig_s): rise = trig_s & ~trig_s_d, fall = ~trig_s & trig_s_d.
- IDLE: on synchronised rise go to TRIG_HI, clear hi_cnt.
- TRIG_HI: hi_cnt increments each cycle while trig_s=1 and saturates at TRIG_MIN_CYC. On fall:
  - hi_cnt >= TRIG_MIN_CYC: latch distance_cm and compute width, then go to BURST.
  - otherwise: pulse short_trig for one cycle and return to IDLE.
  - trig held high indefinitely leaves the block in TRIG_HI.
- Width rule, computed at latch time in 32-bit unsigned:
  - 1 <= distance_cm <= MAX_CM: width = distance_cm * CYC_PER_CM.
  - distance_cm = 0 or > MAX_CM: width = TIMEOUT_CYC.
  - distance_cm changes after latch have no effect on the current measurement.
- BURST: count BURST_CYC cycles, then go to ECHO.
- ECHO: echo=1 for exactly width cycles, then go to HOLDOFF.
- HOLDOFF: echo=0; count HOLDOFF_CYC cycles, then go to IDLE.
- Latency: echo first reads 1 exactly BURST_CYC+3 clk edges after the first edge that samples raw trig=0 (2 synchroniser stages + 1 state register).
- Triggers during BURST, ECHO or HOLDOFF are ignored, with no queueing and no short_trig. A trig that is still high when HOLDOFF ends is not accepted; a fresh synchronised rise is required.
- Counters: single 32-bit down-counter shared by BURST, ECHO and HOLDOFF, reloaded on each state entry. No wrap is possible within the parameter ranges.
- No outputs are combinational from inputs.

Test Plan:
Bench parameters: TRIG_MIN_CYC=5, BURST_CYC=10, CYC_PER_CM=4, MAX_CM=400, TIMEOUT_CYC=2000, HOLDOFF_CYC=50.
1. distance_cm=25; trig high 8 cycles -> echo rises 13 edges after trig falls, stays high exactly 100 cycles; busy high from BURST entry until HOLDOFF ends.
2. Trig high 3 cycles -> single-cycle short_trig, echo never rises, busy stays 0, state back to IDLE.
3. distance_cm=0, then distance_cm=450 (separate runs) -> echo width 2000 cycles each; distance_cm=400 -> width 1600.
4. distance_cm=10, accepted trigger; change distance_cm to 300 during BURST; retrigger during ECHO and during HOLDOFF -> echo width stays 40, only one echo pulse, short_trig stays 0.
5. Assert rst_n low midway through ECHO -> echo=0 and busy=0 without a clock edge; after release, a normal trigger with distance_cm=5 gives a 20-cycle echo.
6. Trig held high 200 cycles, then released, with distance_cm=1 -> accepted; echo width 4 cycles.
